// File: rtl/bft_leaf_endpoint.sv
// Leaf-side endpoint of a BFT link: TX/RX packet FIFOs, ingress drop/resend
// reporting and the page start sequencer.
module bft_leaf_endpoint #(
  parameter logic [4:0] LEAF_ADDR     = 5'd0,
  parameter int         TX_DEPTH      = 8,
  parameter int         RX_DEPTH      = 8,
  parameter int         START_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] tx_pkt_data,
  input  logic        tx_pkt_valid,
  output logic        tx_pkt_ready,
  output logic [48:0] din_leaf_bft2interface,
  input  logic [48:0] dout_leaf_interface2bft,
  output logic [47:0] rx_pkt_data,
  output logic        rx_pkt_valid,
  input  logic        rx_pkt_ready,
  output logic        resend,
  input  logic        start_req,
  output logic        ap_start,
  output logic        leaf_alive,
  output logic [15:0] drop_count
);

  // state  | meaning
  // IDLE   | waiting for start_req, ap_start low
  // START  | ap_start high, waiting for first ingress packet or timeout
  // RETRY  | ap_start low for one cycle before restarting
  // RUN    | page alive, left only by reset
  typedef enum logic [1:0] {S_IDLE, S_START, S_RETRY, S_RUN} state_e;

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int TXCW = TXAW + 1;
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int RXCW = RXAW + 1;
  localparam int TW   = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TXCW-1:0] TX_FULL  = TXCW'(TX_DEPTH);
  localparam logic [RXCW-1:0] RX_FULL  = RXCW'(RX_DEPTH);
  localparam logic [TW-1:0]   TMR_LOAD = TW'(START_TIMEOUT - 1);

  // ---------------- TX path ----------------
  // Address bits of the body are replaced by LEAF_ADDR, so only [42:0] is stored.
  logic [42:0]     tx_mem_q [TX_DEPTH];
  logic [TXAW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TXCW-1:0] tx_count_q;
  logic [48:0]     din_q;
  logic            tx_push, tx_pop;
  logic            unused_tx_addr;

  assign unused_tx_addr = ^tx_pkt_data[47:43];
  assign tx_pkt_ready   = (tx_count_q != TX_FULL);
  assign tx_push        = tx_pkt_valid && tx_pkt_ready;
  assign tx_pop         = (tx_count_q != '0);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= tx_pkt_data[42:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      din_q       <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_q <= tx_count_q + 1'b1;
        2'b01:   tx_count_q <= tx_count_q - 1'b1;
        default: tx_count_q <= tx_count_q;
      endcase
      din_q <= tx_pop ? {1'b1, LEAF_ADDR, tx_mem_q[tx_rd_ptr_q]} : 49'd0;
    end
  end

  assign din_leaf_bft2interface = din_q;

  // ---------------- RX path ----------------
  logic [47:0]     rx_mem_q [RX_DEPTH];
  logic [RXAW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RXCW-1:0] rx_count_q;
  logic            rx_in_valid, rx_full, rx_push, rx_drop, rx_pop;
  logic            resend_q;
  logic [15:0]     drop_count_q;

  // Fullness uses the registered count, so a same-cycle pop never rescues an arrival.
  assign rx_in_valid  = dout_leaf_interface2bft[48];
  assign rx_full      = (rx_count_q == RX_FULL);
  assign rx_push      = rx_in_valid && !rx_full;
  assign rx_drop      = rx_in_valid && rx_full;
  assign rx_pkt_valid = (rx_count_q != '0);
  assign rx_pop       = rx_pkt_ready && rx_pkt_valid;
  assign rx_pkt_data  = rx_mem_q[rx_rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= dout_leaf_interface2bft[47:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      resend_q     <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_q <= rx_count_q + 1'b1;
        2'b01:   rx_count_q <= rx_count_q - 1'b1;
        default: rx_count_q <= rx_count_q;
      endcase
      resend_q <= rx_drop;
      if (rx_drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign resend     = resend_q;
  assign drop_count = drop_count_q;

  // ---------------- Start FSM ----------------
  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            ap_start_q, leaf_alive_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_START;
          tmr_d   = TMR_LOAD;
        end
      end
      S_START: begin
        // Ingress takes priority over a coincident timeout.
        if (rx_in_valid)         state_d = S_RUN;
        else if (tmr_q == '0)    state_d = S_RETRY;
        else                     tmr_d   = tmr_q - 1'b1;
      end
      S_RETRY: begin
        state_d = S_START;
        tmr_d   = TMR_LOAD;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      ap_start_q   <= 1'b0;
      leaf_alive_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      ap_start_q   <= (state_d == S_START);
      leaf_alive_q <= (state_d == S_RUN);
    end
  end

  assign ap_start   = ap_start_q;
  assign leaf_alive = leaf_alive_q;

endmodule

// File: tb/tb_bft_leaf_endpoint.sv
// Directed bench for bft_leaf_endpoint: TX/RX vectors, overflow/resend,
// start sequencing with a short timeout, and asynchronous reset.
module tb_bft_leaf_endpoint;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] tx_pkt_data = '0;
  logic        tx_pkt_valid = 1'b0;
  logic        tx_pkt_ready;
  logic [48:0] din_leaf_bft2interface;
  logic [48:0] dout_leaf_interface2bft = '0;
  logic [47:0] rx_pkt_data;
  logic        rx_pkt_valid;
  logic        rx_pkt_ready = 1'b0;
  logic        resend;
  logic        start_req = 1'b0;
  logic        ap_start;
  logic        leaf_alive;
  logic [15:0] drop_count;

  bft_leaf_endpoint #(
    .LEAF_ADDR(5'd2), .TX_DEPTH(8), .RX_DEPTH(8), .START_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_pkt_data(tx_pkt_data), .tx_pkt_valid(tx_pkt_valid), .tx_pkt_ready(tx_pkt_ready),
    .din_leaf_bft2interface(din_leaf_bft2interface),
    .dout_leaf_interface2bft(dout_leaf_interface2bft),
    .rx_pkt_data(rx_pkt_data), .rx_pkt_valid(rx_pkt_valid), .rx_pkt_ready(rx_pkt_ready),
    .resend(resend), .start_req(start_req), .ap_start(ap_start),
    .leaf_alive(leaf_alive), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        tx_valid;
    logic [47:0] tx_data;
    logic [48:0] dout;
    logic [48:0] exp_din;
    logic        exp_rx_valid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hi_cycles;
    int n_pop;

    // Address field becomes 5'd2 -> bits [47:43] = 00010, i.e. 49'h1_1000_0000_0000 prefix.
    vecs[0] = '{1'b1, 48'h0000_0000_0011, 49'd0,                    49'd0,                    1'b0};
    vecs[1] = '{1'b1, 48'h0000_0000_0022, {1'b0, 48'h0000_0000_DEAD}, 49'h1_1000_0000_0011, 1'b0};
    vecs[2] = '{1'b1, 48'h0000_0000_0033, 49'd0,                    49'h1_1000_0000_0022,     1'b0};
    vecs[3] = '{1'b1, 48'hFFFF_0000_0044, 49'd0,                    49'h1_1000_0000_0033,     1'b0};
    vecs[4] = '{1'b0, 48'h0,              49'd0,                    49'h1_17FF_0000_0044,     1'b0};
    vecs[5] = '{1'b0, 48'h0,              49'd0,                    49'd0,                    1'b0};

    // Reset state
    step();
    step();
    check("rst_din", din_leaf_bft2interface, 0);
    check("rst_resend", resend, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_leaf_alive", leaf_alive, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_rx_valid", rx_pkt_valid, 0);
    check("rst_tx_ready", tx_pkt_ready, 1);
    reset = 1'b0;
    step();

    // TX vectors, with an invalid ingress word that must be ignored
    for (int i = 0; i < 6; i++) begin
      tx_pkt_valid            = vecs[i].tx_valid;
      tx_pkt_data             = vecs[i].tx_data;
      dout_leaf_interface2bft = vecs[i].dout;
      check($sformatf("vec%0d_tx_ready", i), tx_pkt_ready, 1);
      step();
      check($sformatf("vec%0d_din", i), din_leaf_bft2interface, vecs[i].exp_din);
      check($sformatf("vec%0d_rx_valid", i), rx_pkt_valid, vecs[i].exp_rx_valid);
    end

    // 20-packet burst: one per cycle, never back-pressured
    for (int i = 0; i < 20; i++) begin
      tx_pkt_valid = 1'b1;
      tx_pkt_data  = 48'(100 + i);
      check($sformatf("burst%0d_ready", i), tx_pkt_ready, 1);
      step();
      if (i > 0) check($sformatf("burst%0d_din", i - 1), din_leaf_bft2interface,
                       {1'b1, 5'd2, 43'(100 + i - 1)});
    end
    tx_pkt_valid = 1'b0;
    step();
    check("burst19_din", din_leaf_bft2interface, {1'b1, 5'd2, 43'(119)});
    step();
    check("burst_idle_din", din_leaf_bft2interface, 0);

    // RX overflow: 10 packets into an 8-deep FIFO with no pops
    rx_pkt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dout_leaf_interface2bft = {1'b1, 48'(32'hA00 + i)};
      step();
      check($sformatf("ovf%0d_resend", i), resend, (i >= 8) ? 1 : 0);
    end
    dout_leaf_interface2bft = '0;
    step();
    check("ovf_resend_end", resend, 0);
    check("ovf_drop_count", drop_count, 2);
    rx_pkt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_pop%0d_valid", k), rx_pkt_valid, 1);
      check($sformatf("ovf_pop%0d_data", k), rx_pkt_data, 48'(32'hA00 + k));
      step();
    end
    check("ovf_empty", rx_pkt_valid, 0);

    // RX full with simultaneous pop and arrival: arrival dropped
    rx_pkt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dout_leaf_interface2bft = {1'b1, 48'(32'hB00 + i)};
      step();
    end
    rx_pkt_ready            = 1'b1;
    dout_leaf_interface2bft = {1'b1, 48'h0000_0000_0C00};
    step();
    check("fullpop_resend", resend, 1);
    check("fullpop_drop_count", drop_count, 3);
    dout_leaf_interface2bft = '0;
    n_pop = 0;
    for (int k = 0; k < 20; k++) begin
      if (!rx_pkt_valid) break;
      check($sformatf("fullpop_data%0d", n_pop), rx_pkt_data, 48'(32'hB01 + n_pop));
      n_pop++;
      step();
    end
    check("fullpop_remaining", n_pop, 7);
    check("fullpop_resend_end", resend, 0);
    rx_pkt_ready = 1'b0;

    // Start FSM with START_TIMEOUT = 16
    check("idle_ap_start", ap_start, 0);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    check("start_ap_start", ap_start, 1);
    hi_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      if (!ap_start) break;
      hi_cycles++;
      step();
    end
    check("start_high_cycles", hi_cycles, 16);
    check("retry_ap_start", ap_start, 0);
    check("retry_alive", leaf_alive, 0);
    step();
    check("restart_ap_start", ap_start, 1);
    step();
    dout_leaf_interface2bft = {1'b1, 48'h0000_0000_0ABC};
    step();
    dout_leaf_interface2bft = '0;
    check("run_ap_start", ap_start, 0);
    check("run_alive", leaf_alive, 1);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    check("run_ignore_start_ap", ap_start, 0);
    check("run_ignore_start_alive", leaf_alive, 1);

    // Asynchronous reset in RUN with both FIFOs occupied
    tx_pkt_valid = 1'b1;
    tx_pkt_data  = 48'h0000_0000_0077;
    step();
    tx_pkt_data  = 48'h0000_0000_0088;
    step();
    tx_pkt_valid = 1'b0;
    check("pre_rst_din", din_leaf_bft2interface, 49'h1_1000_0000_0077);
    check("pre_rst_rx_valid", rx_pkt_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_din", din_leaf_bft2interface, 0);
    check("arst_rx_valid", rx_pkt_valid, 0);
    check("arst_tx_ready", tx_pkt_ready, 1);
    check("arst_resend", resend, 0);
    check("arst_ap_start", ap_start, 0);
    check("arst_alive", leaf_alive, 0);
    check("arst_drop_count", drop_count, 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_din", din_leaf_bft2interface, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bft_leaf_endpoint.md
Name: bft_leaf_endpoint

Overview:
- Network-side endpoint of one BFT leaf link; the opposite end of a page's leaf interface.
- Drives `din_leaf_bft2interface` toward the page and absorbs `dout_leaf_interface2bft` from it.
- Buffers both directions, reports dropped ingress packets to the page by pulsing `resend`, and sequences the page's `ap_start`.
- Used in leaf-level test harnesses and as the leaf port of a BFT switch.

Parameters:
- LEAF_ADDR, 5'd0, this leaf's address; forced into bits [47:43] of every packet sent to the page.
- TX_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 8, RX FIFO entries; power of 2, at least 2.
- START_TIMEOUT, 1024, cycles to wait in START for a first packet before retrying.

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- tx_pkt_data  in  48  packet body to send to the page; bit 48 (valid) is added by the block
- tx_pkt_valid  in  1  upstream offers a TX packet
- tx_pkt_ready  out  1  TX FIFO not full
- din_leaf_bft2interface  out  49  registered link toward the page; bit 48 = valid
- dout_leaf_interface2bft  in  49  link from the page; bit 48 = valid
- rx_pkt_data  out  48  head of RX FIFO, bits [47:0]
- rx_pkt_valid  out  1  RX FIFO not empty
- rx_pkt_ready  in  1  downstream pops the RX head
- resend  out  1  one-cycle request telling the page to retransmit
- start_req  in  1  pulse; begin the start sequence
- ap_start  out  1  page start strobe
- leaf_alive  out  1  high in RUN state
- drop_count  out  16  saturating count of dropped ingress packets

Behaviour:
- Reset values: `din_leaf_bft2interface`=0, `resend`=0, `ap_start`=0, `leaf_alive`=0, `drop_count`=0, both FIFOs empty, so `rx_pkt_valid`=0 and `tx_pkt_ready`=1. FSM = IDLE.
- Reset asserted mid-operation flushes both FIFOs immediately; in-flight data is lost.

TX path:
- A packet is pushed when `tx_pkt_valid` and `tx_pkt_ready` are both high on a clock edge.
- Each cycle the FIFO is non-empty, the head is popped and registered as {1'b1, LEAF_ADDR, data[42:0]}.
- Otherwise the output register loads 49'd0.
- One packet per cycle maximum. Latency from push into an empty FIFO to the packet on `din_leaf_bft2interface` is 2 edges.
- Simultaneous push and pop while full is legal; `tx_pkt_ready` is based on the registered count and is low only when count == TX_DEPTH.

RX path:
- When bit 48 of `dout_leaf_interface2bft` is 1 and the RX FIFO is not full, push bits [47:0].
- When bit 48 is 1 and the FIFO is full, drop the packet. Fullness is evaluated before any same-cycle pop, so a pop does not rescue a packet arriving at full.
- On a drop: `resend`=1 on the next cycle only, and `drop_count` increments, saturating at 16'hFFFF.
- Back-to-back drops keep `resend` high for consecutive cycles.
- The RX FIFO is show-ahead: `rx_pkt_valid` rises 1 edge after the first push into an empty FIFO, and `rx_pkt_data` is valid whenever `rx_pkt_valid`=1.
- A packet with bit 48 = 0 is ignored entirely.

Start FSM:
- IDLE: `ap_start`=0. `start_req` moves to START and clears the timeout counter.
- START: `ap_start`=1.
  - The first valid ingress packet moves to RUN, whether it is pushed or dropped.
  - If the timeout counter reaches START_TIMEOUT-1 first, go to RETRY.
- RETRY: `ap_start`=0 for exactly 1 cycle, then return to START with the counter cleared.
- RUN: `ap_start`=0, `leaf_alive`=1. Only reset leaves RUN.
- `start_req` outside IDLE is ignored.
- Valid ingress and timeout expiry in the same cycle: ingress wins, go to RUN.
- All FSM outputs are registered.

Test Plan:
- Reset, then push 3 packets with data 48'h0000_0000_0011/22/33 and LEAF_ADDR=5'd2 → `din_leaf_bft2interface` shows 3 consecutive valid words.
  - Bits [47:43]=2 on each; the bits below match the input body.
  - First word appears 2 edges after the first push; the link returns to 0 afterwards.
- Fill the TX FIFO with 8 packets while `din` draining is simultaneous → `tx_pkt_ready` never drops.
  - Holding output? Not applicable: output cannot stall, so verify throughput is 1 per cycle and no loss after a 20-packet burst.
- `rx_pkt_ready`=0, then drive 10 valid ingress words → first 8 stored, packets 9 and 10 dropped.
  - `resend` high for 2 consecutive cycles; `drop_count`=2.
  - Pop all entries → 8 entries come out in order.
- RX full plus simultaneous pop and valid ingress → packet dropped, `resend`=1, count after = 7.
- START_TIMEOUT=16: `start_req` pulse with no ingress → `ap_start` high 16 cycles, low 1 cycle, high again.
  - Inject a valid packet → `ap_start`=0 and `leaf_alive`=1 on the next edge.
- Assert reset while RUN with both FIFOs non-empty → all outputs return to reset values asynchronously, before the next clock edge.
